// File: rtl/rnbip_ctrl_seq.sv
// Instruction sequencer / control unit in front of the 8 x 8-bit dual-port register file.
// Latency: FETCH->WRITE is 4 cycles (IN), 6 (LDI), 5+ (ALU, plus extra alu_done wait), NOP retires in 3.
// Backpressure: hold freezes all state and outputs; ALU_WAIT stalls indefinitely until alu_done.
//
// Ports:
//   clk, clr        clock, synchronous active-high reset
//   hold            stall, freezes every register and output
//   pc / imem_rdata program ROM address / data (data valid one cycle after pc)
//   alu_start       one-cycle ALU request pulse; alu_done reports ALU_IN valid
//   we, mux_sel, read_seg, write_seg, OR2   register file controls and immediate operand
//   halted          high in HALT; instr_count retired instructions (saturating)
module rnbip_ctrl_seq #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             hold,
  output logic [PC_W-1:0]  pc,
  input  logic [7:0]       imem_rdata,
  output logic             alu_start,
  input  logic             alu_done,
  output logic             we,
  output logic [1:0]       mux_sel,
  output logic [2:0]       read_seg,
  output logic [2:0]       write_seg,
  output logic [7:0]       OR2,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_LATCH,
    S_DECODE,
    S_IMM_FETCH,
    S_IMM_LATCH,
    S_ALU_WAIT,
    S_WRITE,
    S_HALT
  } state_t;

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_LDI = 2'b01;
  localparam logic [1:0] CLS_IN  = 2'b10;

  state_t           r_state;
  state_t           w_next_state;
  logic [PC_W-1:0]  r_pc;
  logic [7:0]       r_ir;
  logic [7:0]       r_or2;
  logic [1:0]       r_mux_sel;
  logic [2:0]       r_read_seg;
  logic [2:0]       r_write_seg;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0] w_cls;
  logic [2:0] w_ddd;
  logic [2:0] w_sss;
  logic       w_is_halt;
  logic [1:0] w_mux_next;
  logic       w_alu_start;
  logic       w_we;
  logic       w_halted;
  logic       w_retire;

  assign w_cls     = r_ir[7:6];
  assign w_ddd     = r_ir[5:3];
  assign w_sss     = r_ir[2:0];
  assign w_is_halt = (r_ir == 8'hFF);

  // Write-data source for the pending WRITE; IN picks B_in when sss[0] is set.
  always_comb begin
    w_mux_next = 2'b00;
    case (w_cls)
      CLS_ALU: w_mux_next = 2'b00;
      CLS_LDI: w_mux_next = 2'b11;
      CLS_IN:  w_mux_next = w_sss[0] ? 2'b01 : 2'b10;
      default: w_mux_next = 2'b00;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_alu_start  = 1'b0;
    w_we         = 1'b0;
    w_halted     = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      S_FETCH:     w_next_state = S_LATCH;
      S_LATCH:     w_next_state = S_DECODE;
      S_DECODE: begin
        case (w_cls)
          CLS_ALU: begin
            w_alu_start  = 1'b1;
            w_next_state = S_ALU_WAIT;
          end
          CLS_LDI: w_next_state = S_IMM_FETCH;
          CLS_IN:  w_next_state = S_WRITE;
          default: begin
            if (w_is_halt) begin
              w_next_state = S_HALT;
            end else begin
              w_retire     = 1'b1;
              w_next_state = S_FETCH;
            end
          end
        endcase
      end
      S_IMM_FETCH: w_next_state = S_IMM_LATCH;
      S_IMM_LATCH: w_next_state = S_WRITE;
      S_ALU_WAIT:  if (alu_done) w_next_state = S_WRITE;
      S_WRITE: begin
        w_we         = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_HALT:      w_halted = 1'b1;
      default:     w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= S_FETCH;
      r_pc        <= '0;
      r_ir        <= '0;
      r_or2       <= '0;
      r_mux_sel   <= 2'b00;
      r_read_seg  <= '0;
      r_write_seg <= '0;
      r_cnt       <= '0;
    end else if (!hold) begin
      r_state <= w_next_state;
      if (r_state == S_LATCH) begin
        r_ir <= imem_rdata;
        r_pc <= r_pc + PC_W'(1);
      end
      if (r_state == S_IMM_LATCH) begin
        r_or2 <= imem_rdata;
        r_pc  <= r_pc + PC_W'(1);
      end
      if (r_state == S_DECODE && w_cls == CLS_ALU) begin
        r_read_seg <= w_sss;
      end
      // Load write controls on the edge entering WRITE so they are stable
      // for the whole write and hold afterwards.
      if (w_next_state == S_WRITE && r_state != S_WRITE) begin
        r_mux_sel   <= w_mux_next;
        r_write_seg <= w_ddd;
      end
      if (w_retire && r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // State-decoded strobes stay frozen under hold because the state does.
  assign alu_start   = w_alu_start;
  assign we          = w_we;
  assign halted      = w_halted;
  assign pc          = r_pc;
  assign OR2         = r_or2;
  assign mux_sel     = r_mux_sel;
  assign read_seg    = r_read_seg;
  assign write_seg   = r_write_seg;
  assign instr_count = r_cnt;

endmodule

// File: tb/tb_rnbip_ctrl_seq.sv
module tb_rnbip_ctrl_seq;

  logic       clk;
  logic       clr;
  logic       hold;
  logic [7:0] pc;
  logic [7:0] imem_rdata;
  logic       alu_start;
  logic       alu_done;
  logic       we;
  logic [1:0] mux_sel;
  logic [2:0] read_seg;
  logic [2:0] write_seg;
  logic [7:0] OR2;
  logic       halted;
  logic [7:0] instr_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rom [0:255];

  rnbip_ctrl_seq #(.PC_W(8), .CNT_W(8)) dut (
    .clk        (clk),
    .clr        (clr),
    .hold       (hold),
    .pc         (pc),
    .imem_rdata (imem_rdata),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .we         (we),
    .mux_sel    (mux_sel),
    .read_seg   (read_seg),
    .write_seg  (write_seg),
    .OR2        (OR2),
    .halted     (halted),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program ROM: data appears one cycle after the address.
  always_ff @(posedge clk) imem_rdata <= rom[pc];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] val);
    for (int i = 0; i < 256; i++) rom[i] = val;
  endtask

  // After this returns the DUT is in its first FETCH cycle.
  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  int starts;
  int k;

  initial begin
    clr = 1'b0; hold = 1'b0; alu_done = 1'b0;
    fill(8'hFF);

    // LDI r1,0xFE
    rom[0] = 8'h4A; rom[1] = 8'hFE;
    do_clr();
    chk("rst_pc", pc, 0);
    chk("rst_we", we, 0);
    chk("rst_mux", mux_sel, 0);
    chk("rst_rseg", read_seg, 0);
    chk("rst_wseg", write_seg, 0);
    chk("rst_or2", OR2, 0);
    chk("rst_start", alu_start, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cnt", instr_count, 0);
    repeat (4) step();
    chk("ldi_c5_we", we, 0);
    step();
    chk("ldi_we", we, 1);
    chk("ldi_mux", mux_sel, 3);
    chk("ldi_wseg", write_seg, 1);
    chk("ldi_or2", OR2, 8'hFE);
    chk("ldi_pc", pc, 2);
    step();
    chk("ldi_we_drop", we, 0);
    chk("ldi_cnt", instr_count, 1);
    chk("ldi_mux_hold", mux_sel, 3);

    // IN r2,A ; IN r3,B
    fill(8'hFF);
    rom[0] = 8'h90; rom[1] = 8'h99;
    do_clr();
    repeat (3) step();
    chk("in1_we", we, 1);
    chk("in1_mux", mux_sel, 2);
    chk("in1_wseg", write_seg, 2);
    step();
    chk("in1_we_drop", we, 0);
    chk("in1_mux_hold", mux_sel, 2);
    repeat (3) step();
    chk("in2_we", we, 1);
    chk("in2_mux", mux_sel, 1);
    chk("in2_wseg", write_seg, 3);
    step();
    chk("in_cnt", instr_count, 2);

    // ALU r1<-r5, alu_done three cycles after alu_start
    fill(8'hFF);
    rom[0] = 8'h0D;
    do_clr();
    starts = 0;
    starts += int'(alu_start);
    step();                       // LATCH: a stray alu_done is ignored here
    alu_done = 1'b1;
    starts += int'(alu_start);
    step();                       // DECODE
    alu_done = 1'b0;
    chk("alu_start_pulse", alu_start, 1);
    starts += int'(alu_start);
    step();                       // ALU_WAIT #1
    chk("alu_start_off", alu_start, 0);
    chk("alu_rseg", read_seg, 5);
    chk("alu_wait_we", we, 0);
    starts += int'(alu_start);
    step();                       // ALU_WAIT #2
    starts += int'(alu_start);
    step();                       // ALU_WAIT #3
    alu_done = 1'b1;
    chk("alu_wait3_we", we, 0);
    starts += int'(alu_start);
    step();                       // WRITE
    alu_done = 1'b0;
    chk("alu_we", we, 1);
    chk("alu_mux", mux_sel, 0);
    chk("alu_wseg", write_seg, 1);
    chk("alu_rseg_hold", read_seg, 5);
    starts += int'(alu_start);
    chk("alu_start_count", starts, 1);

    // NOP then HALT
    fill(8'hFF);
    rom[0] = 8'hC0;
    do_clr();
    repeat (2) step();
    chk("nop_decode_we", we, 0);
    step();
    chk("nop_cnt", instr_count, 1);
    chk("nop_pc", pc, 1);
    repeat (3) step();
    chk("halt_flag", halted, 1);
    chk("halt_pc", pc, 2);
    repeat (4) step();
    chk("halt_stay", halted, 1);
    chk("halt_pc_frozen", pc, 2);
    chk("halt_we", we, 0);
    chk("halt_cnt", instr_count, 1);
    do_clr();
    chk("halt_clr_pc", pc, 0);
    chk("halt_clr_flag", halted, 0);

    // clr during ALU_WAIT, even with alu_done present
    fill(8'hFF);
    rom[0] = 8'h0D;
    do_clr();
    repeat (3) step();            // ALU_WAIT
    alu_done = 1'b1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    alu_done = 1'b0;
    chk("clr_alu_pc", pc, 0);
    chk("clr_alu_we", we, 0);
    chk("clr_alu_cnt", instr_count, 0);

    // clr during IMM_LATCH of the second of two LDIs
    fill(8'hFF);
    rom[0] = 8'h4A; rom[1] = 8'h77; rom[2] = 8'h4B; rom[3] = 8'h55;
    do_clr();
    repeat (5) step();            // first WRITE
    chk("clr_imm_or2_pre", OR2, 8'h77);
    repeat (5) step();            // second IMM_LATCH
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_imm_pc", pc, 0);
    chk("clr_imm_we", we, 0);
    chk("clr_imm_or2", OR2, 0);
    chk("clr_imm_cnt", instr_count, 0);

    // LDI straddling the pc wrap, hold during WRITE, then saturation
    fill(8'hC0);
    rom[8'hFE] = 8'h4A; rom[8'hFF] = 8'h3C;
    do_clr();
    k = 0;
    while (we !== 1'b1 && k < 2000) begin
      step();
      k++;
    end
    chk("wrap_reach_write", (k < 2000), 1);
    chk("wrap_pc", pc, 0);
    chk("wrap_or2", OR2, 8'h3C);
    chk("wrap_mux", mux_sel, 3);
    chk("wrap_wseg", write_seg, 1);
    chk("wrap_cnt_pre", instr_count, 254);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_we", we, 1);
      chk("hold_cnt", instr_count, 254);
      chk("hold_pc", pc, 0);
    end
    hold = 1'b0;
    step();
    chk("hold_rel_we", we, 0);
    chk("hold_rel_cnt", instr_count, 255);
    chk("hold_rel_pc", pc, 0);
    repeat (3) step();
    chk("sat_cnt", instr_count, 255);
    chk("sat_pc", pc, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
